// File: rtl/excp_commit_unit_pkg.sv
// Shared types for the commit-side exception/interrupt arbiter:
// exception-cause layout, TLB fault flags, lane bundle and FSM encodings.
package excp_commit_unit_pkg;

    localparam int unsigned ETYPE_W = 12;

    typedef struct packed {
        logic adel_if;
        logic adel_ld;
        logic ades;
        logic ri;
        logic ov;
        logic sys;
        logic bp;
        logic tr;
        logic cpu;
        logic fpe;
        logic watch;
        logic mcheck;
    } excp_type_t;

    typedef struct packed {
        logic refill;
        logic invalid;
        logic modified;
    } tlb_exc_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        branch;
        excp_type_t  etype;
        tlb_exc_t    itlb;
        tlb_exc_t    dtlb;
        logic [31:0] vaddr;
        logic        eret;
    } commit_lane_t;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REDIRECT = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;

    function automatic logic lane_has_exc(commit_lane_t l);
        return l.valid && ((|l.etype) || (|l.itlb) || (|l.dtlb));
    endfunction

endpackage

// File: rtl/excp_commit_unit_if.sv
// Bundle of retiring-lane inputs, CP0 feedback and CP0/fetch event outputs.
interface excp_commit_unit_if;
    import excp_commit_unit_pkg::*;

    logic        stall;
    logic        l0_valid, l1_valid;
    logic [31:0] l0_pc, l1_pc;
    logic        l0_branch, l1_branch;
    excp_type_t  l0_etype, l1_etype;
    tlb_exc_t    l0_itlb, l1_itlb, l0_dtlb, l1_dtlb;
    logic [31:0] l0_vaddr, l1_vaddr;
    logic        l0_eret, l1_eret;
    logic        cp0_is_int;
    logic [31:0] cp0_entrance;
    logic [31:0] cp0_epc;

    logic        exc_valid;
    excp_type_t  exc_etype;
    tlb_exc_t    exc_itlb, exc_dtlb;
    logic [31:0] exc_pc, exc_vaddr;
    logic        exc_slot;
    logic        inter_valid;
    logic [31:0] int_pc;
    logic        int_slot;
    logic        eret_out;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        l0_commit, l1_commit;

    modport mst (
        output stall, l0_valid, l1_valid, l0_pc, l1_pc, l0_branch, l1_branch,
               l0_etype, l1_etype, l0_itlb, l1_itlb, l0_dtlb, l1_dtlb,
               l0_vaddr, l1_vaddr, l0_eret, l1_eret,
               cp0_is_int, cp0_entrance, cp0_epc,
        input  exc_valid, exc_etype, exc_itlb, exc_dtlb, exc_pc, exc_vaddr, exc_slot,
               inter_valid, int_pc, int_slot, eret_out, flush,
               redirect_valid, redirect_pc, l0_commit, l1_commit
    );

    modport slv (
        input  stall, l0_valid, l1_valid, l0_pc, l1_pc, l0_branch, l1_branch,
               l0_etype, l1_etype, l0_itlb, l1_itlb, l0_dtlb, l1_dtlb,
               l0_vaddr, l1_vaddr, l0_eret, l1_eret,
               cp0_is_int, cp0_entrance, cp0_epc,
        output exc_valid, exc_etype, exc_itlb, exc_dtlb, exc_pc, exc_vaddr, exc_slot,
               inter_valid, int_pc, int_slot, eret_out, flush,
               redirect_valid, redirect_pc, l0_commit, l1_commit
    );

endinterface

// File: rtl/excp_commit_unit_lane_sel.sv
// Combinational priority select of at most one precise event across the two
// retiring lanes, plus the per-lane commit permissions that follow from it.
module excp_lane_sel
    import excp_commit_unit_pkg::*;
(
    input  commit_lane_t l0,
    input  commit_lane_t l1,
    input  logic         live,
    input  logic         last_branch,
    input  logic         cp0_is_int,
    output logic         take_int,
    output logic         take_exc,
    output logic         take_eret,
    output logic [31:0]  int_pc,
    output logic         int_slot,
    output excp_type_t   exc_etype,
    output tlb_exc_t     exc_itlb,
    output tlb_exc_t     exc_dtlb,
    output logic [31:0]  exc_pc,
    output logic [31:0]  exc_vaddr,
    output logic         exc_slot,
    output logic         l0_commit,
    output logic         l1_commit,
    output logic         commit_branch
);

    logic l0_slot;
    logic l1_slot;

    assign l0_slot = last_branch;
    assign l1_slot = l0.branch;

    always_comb begin
        take_int  = 1'b0;
        take_exc  = 1'b0;
        take_eret = 1'b0;
        int_pc    = '0;
        int_slot  = 1'b0;
        exc_etype = '0;
        exc_itlb  = '0;
        exc_dtlb  = '0;
        exc_pc    = '0;
        exc_vaddr = '0;
        exc_slot  = 1'b0;
        l0_commit = 1'b0;
        l1_commit = 1'b0;
        if (live) begin
            if (cp0_is_int && l0.valid) begin
                take_int = 1'b1;
                int_pc   = l0.pc;
                int_slot = l0_slot;
            end else if (lane_has_exc(l0)) begin
                take_exc  = 1'b1;
                exc_etype = l0.etype;
                exc_itlb  = l0.itlb;
                exc_dtlb  = l0.dtlb;
                exc_pc    = l0.pc;
                exc_vaddr = l0.vaddr;
                exc_slot  = l0_slot;
            end else if (l0.valid && l0.eret) begin
                take_eret = 1'b1;
                l0_commit = 1'b1;
            end else if (lane_has_exc(l1)) begin
                take_exc  = 1'b1;
                exc_etype = l1.etype;
                exc_itlb  = l1.itlb;
                exc_dtlb  = l1.dtlb;
                exc_pc    = l1.pc;
                exc_vaddr = l1.vaddr;
                exc_slot  = l1_slot;
                l0_commit = 1'b1;
            end else if (l1.valid && l1.eret) begin
                take_eret = 1'b1;
                l0_commit = 1'b1;
                l1_commit = 1'b1;
            end else begin
                l0_commit = l0.valid;
                l1_commit = l1.valid;
            end
        end
    end

    // Branch flag of the youngest lane that actually commits this cycle.
    assign commit_branch = l1_commit ? l1.branch : l0.branch;

endmodule

// File: rtl/excp_commit_unit.sv
// Commit-side exception/interrupt arbiter: drives CP0 event inputs and
// sequences flush, fetch redirect and front-end drain after each event.
module excp_commit_unit
    import excp_commit_unit_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    excp_commit_unit_if.slv        bus
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      target_q, target_d;
    logic             last_branch_q, last_branch_d;

    commit_lane_t l0, l1;
    logic         live;
    logic         take_int, take_exc, take_eret;
    logic         l0_commit, l1_commit, commit_branch;

    assign l0 = '{pc: bus.l0_pc, valid: bus.l0_valid, branch: bus.l0_branch,
                  etype: bus.l0_etype, itlb: bus.l0_itlb, dtlb: bus.l0_dtlb,
                  vaddr: bus.l0_vaddr, eret: bus.l0_eret};
    assign l1 = '{pc: bus.l1_pc, valid: bus.l1_valid, branch: bus.l1_branch,
                  etype: bus.l1_etype, itlb: bus.l1_itlb, dtlb: bus.l1_dtlb,
                  vaddr: bus.l1_vaddr, eret: bus.l1_eret};

    // Reset is folded in so nothing reaches CP0 while the FSM is being cleared.
    assign live = (state_q == IDLE) && !bus.stall && !reset;

    excp_lane_sel u_sel (
        .l0            (l0),
        .l1            (l1),
        .live          (live),
        .last_branch   (last_branch_q),
        .cp0_is_int    (bus.cp0_is_int),
        .take_int      (take_int),
        .take_exc      (take_exc),
        .take_eret     (take_eret),
        .int_pc        (bus.int_pc),
        .int_slot      (bus.int_slot),
        .exc_etype     (bus.exc_etype),
        .exc_itlb      (bus.exc_itlb),
        .exc_dtlb      (bus.exc_dtlb),
        .exc_pc        (bus.exc_pc),
        .exc_vaddr     (bus.exc_vaddr),
        .exc_slot      (bus.exc_slot),
        .l0_commit     (l0_commit),
        .l1_commit     (l1_commit),
        .commit_branch (commit_branch)
    );

    assign bus.exc_valid   = take_exc;
    assign bus.inter_valid = take_int;
    assign bus.eret_out    = take_eret;
    assign bus.l0_commit   = l0_commit;
    assign bus.l1_commit   = l1_commit;

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        target_d           = target_q;
        last_branch_d      = last_branch_q;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        case (state_q)
            IDLE: begin
                if (l0_commit || l1_commit) begin
                    last_branch_d = commit_branch;
                end
                if (take_int || take_exc) begin
                    target_d = bus.cp0_entrance;
                    state_d  = REDIRECT;
                end else if (take_eret) begin
                    target_d = bus.cp0_epc;
                    state_d  = REDIRECT;
                end
            end
            REDIRECT: begin
                bus.flush          = !reset;
                bus.redirect_valid = !reset;
                bus.redirect_pc    = reset ? '0 : target_q;
                last_branch_d      = 1'b0;
                cnt_d              = CNT_W'(DRAIN_CYCLES);
                state_d            = (DRAIN_CYCLES == 0) ? IDLE : DRAIN;
            end
            DRAIN: begin
                // Counter holds the remaining drain cycles including this one.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            target_q      <= '0;
            last_branch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            target_q      <= target_d;
            last_branch_q <= last_branch_d;
        end
    end

endmodule

// File: tb/tb_excp_commit_unit.sv
module tb_excp_commit_unit;
  import excp_commit_unit_pkg::*;

  typedef struct packed {
    logic        inter_valid;
    logic [31:0] int_pc;
    logic        int_slot;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        exc_slot;
    logic [31:0] exc_vaddr;
    logic [11:0] exc_etype;
    logic [2:0]  exc_itlb;
    logic [2:0]  exc_dtlb;
    logic        eret_out;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        l0_commit;
    logic        l1_commit;
  } obs_t;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam logic [31:0] EPC = 32'h8000_3000;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  obs_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  excp_commit_unit_if bus ();

  excp_commit_unit #(.DRAIN_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic obs_t sample();
    obs_t o;
    o.inter_valid    = bus.inter_valid;
    o.int_pc         = bus.int_pc;
    o.int_slot       = bus.int_slot;
    o.exc_valid      = bus.exc_valid;
    o.exc_pc         = bus.exc_pc;
    o.exc_slot       = bus.exc_slot;
    o.exc_vaddr      = bus.exc_vaddr;
    o.exc_etype      = bus.exc_etype;
    o.exc_itlb       = bus.exc_itlb;
    o.exc_dtlb       = bus.exc_dtlb;
    o.eret_out       = bus.eret_out;
    o.flush          = bus.flush;
    o.redirect_valid = bus.redirect_valid;
    o.redirect_pc    = bus.redirect_pc;
    o.l0_commit      = bus.l0_commit;
    o.l1_commit      = bus.l1_commit;
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = sample();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  function automatic obs_t commit(logic c0, logic c1);
    obs_t o = '0;
    o.l0_commit = c0;
    o.l1_commit = c1;
    return o;
  endfunction

  function automatic obs_t redir(logic [31:0] pc);
    obs_t o = '0;
    o.flush          = 1'b1;
    o.redirect_valid = 1'b1;
    o.redirect_pc    = pc;
    return o;
  endfunction

  task automatic step(string n, obs_t e);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.stall      = 1'b0;
    bus.cp0_is_int = 1'b0;
    bus.l0_valid = 1'b0; bus.l1_valid = 1'b0;
    bus.l0_pc    = '0;   bus.l1_pc    = '0;
    bus.l0_branch = 1'b0; bus.l1_branch = 1'b0;
    bus.l0_etype = '0;   bus.l1_etype = '0;
    bus.l0_itlb  = '0;   bus.l1_itlb  = '0;
    bus.l0_dtlb  = '0;   bus.l1_dtlb  = '0;
    bus.l0_vaddr = '0;   bus.l1_vaddr = '0;
    bus.l0_eret  = 1'b0; bus.l1_eret  = 1'b0;
  endtask

  task automatic redirect_drain(string n, logic [31:0] pc);
    clr();
    bus.l0_valid = 1'b1;
    bus.l1_valid = 1'b1;
    step({n, "_redirect"}, redir(pc));
    step({n, "_drain0"}, '0);
    step({n, "_drain1"}, '0);
  endtask

  initial begin
    obs_t       e;
    excp_type_t et;
    tlb_exc_t   tl;

    clr();
    bus.cp0_entrance = VEC;
    bus.cp0_epc      = EPC;
    reset = 1'b1;
    @(posedge clk);
    #1;

    bus.l0_valid = 1'b1; bus.cp0_is_int = 1'b1; bus.l0_pc = 32'hBFC0_0010;
    step("reset0", '0);
    step("reset1", '0);
    reset = 1'b0;

    e = '0; e.inter_valid = 1'b1; e.int_pc = 32'hBFC0_0010;
    step("int_take", e);
    total++;
    if (bus.redirect_pc !== VEC || bus.flush !== 1'b1) begin
      bad++;
      $display("FAIL int_redirect_direct: got pc=%h flush=%b expected pc=%h flush=1",
               bus.redirect_pc, bus.flush, VEC);
    end
    redirect_drain("int", VEC);
    step("int_resume", commit(1'b1, 1'b1));

    clr();
    bus.l0_valid = 1'b1; bus.l0_pc = 32'h8000_0FFC;
    bus.l1_valid = 1'b1; bus.l1_pc = 32'h8000_1000; bus.l1_branch = 1'b1;
    step("branch_l1", commit(1'b1, 1'b1));
    clr();
    et = '0; et.ov = 1'b1;
    bus.l0_valid = 1'b1; bus.l0_pc = 32'h8000_1004; bus.l0_etype = et;
    bus.l0_vaddr = 32'h0000_1234;
    bus.l1_valid = 1'b1; bus.l1_pc = 32'h8000_1008;
    e = '0; e.exc_valid = 1'b1; e.exc_pc = 32'h8000_1004; e.exc_slot = 1'b1;
    e.exc_etype = et; e.exc_vaddr = 32'h0000_1234;
    step("slot_overflow", e);
    redirect_drain("ov", VEC);

    clr();
    et = '0; et.sys = 1'b1;
    bus.l0_valid = 1'b1; bus.l0_pc = 32'h8000_2000;
    bus.l1_valid = 1'b1; bus.l1_pc = 32'h8000_2004; bus.l1_etype = et;
    e = commit(1'b1, 1'b0); e.exc_valid = 1'b1; e.exc_pc = 32'h8000_2004;
    e.exc_etype = et;
    step("l1_syscall", e);
    redirect_drain("sys", VEC);

    clr();
    tl = '0; tl.refill = 1'b1;
    bus.l0_valid = 1'b1; bus.l0_pc = 32'h8000_2100; bus.l0_branch = 1'b1;
    bus.l1_valid = 1'b1; bus.l1_pc = 32'h8000_2104; bus.l1_itlb = tl;
    e = commit(1'b1, 1'b0); e.exc_valid = 1'b1; e.exc_pc = 32'h8000_2104;
    e.exc_slot = 1'b1; e.exc_itlb = 3'b100;
    step("l1_itlb_slot", e);
    redirect_drain("itlb", VEC);

    clr();
    bus.l0_valid = 1'b1; bus.l0_pc = 32'h8000_2200; bus.l0_eret = 1'b1;
    bus.l1_valid = 1'b1; bus.l1_pc = 32'h8000_2204;
    e = commit(1'b1, 1'b0); e.eret_out = 1'b1;
    step("l0_eret", e);
    total++;
    if (bus.redirect_pc !== EPC) begin
      bad++;
      $display("FAIL eret_redirect_direct: got %h expected %h", bus.redirect_pc, EPC);
    end
    redirect_drain("eret0", EPC);

    clr();
    bus.l0_valid = 1'b1; bus.l0_pc = 32'h8000_2300;
    bus.l1_valid = 1'b1; bus.l1_pc = 32'h8000_2304; bus.l1_eret = 1'b1;
    e = commit(1'b1, 1'b1); e.eret_out = 1'b1;
    step("l1_eret", e);
    redirect_drain("eret1", EPC);

    clr();
    tl = '0; tl.refill = 1'b1;
    bus.cp0_is_int = 1'b1;
    bus.l0_valid = 1'b1; bus.l0_pc = 32'h8000_4000; bus.l0_dtlb = tl;
    bus.l0_vaddr = 32'h0040_0000;
    e = '0; e.inter_valid = 1'b1; e.int_pc = 32'h8000_4000;
    step("int_over_dtlb", e);
    redirect_drain("int2", VEC);

    clr();
    bus.cp0_is_int = 1'b1;
    bus.l1_valid = 1'b1; bus.l1_pc = 32'h8000_4104;
    step("int_no_l0", commit(1'b0, 1'b1));

    clr();
    bus.l0_valid = 1'b1; bus.l0_pc = 32'h8000_5000;
    bus.l1_valid = 1'b1; bus.l1_pc = 32'h8000_5004; bus.l1_branch = 1'b1;
    step("branch_l1_b", commit(1'b1, 1'b1));
    clr();
    et = '0; et.ri = 1'b1;
    bus.stall = 1'b1;
    bus.l0_valid = 1'b1; bus.l0_pc = 32'h8000_5008; bus.l0_etype = et;
    step("stall_hides_exc", '0);
    bus.stall = 1'b0;
    e = '0; e.exc_valid = 1'b1; e.exc_pc = 32'h8000_5008; e.exc_slot = 1'b1;
    e.exc_etype = et;
    step("slot_held_by_stall", e);

    clr();
    bus.l0_valid = 1'b1; bus.l1_valid = 1'b1;
    step("ri_redirect", redir(VEC));
    reset = 1'b1;
    step("reset_in_drain", '0);
    reset = 1'b0;
    step("after_reset_commit", commit(1'b1, 1'b1));

    clr();
    step("idle_tail", '0);
    @(posedge clk);
    #1;

    if (total < 12) begin
      bad++;
      $display("FAIL check_count: got %0d expected at least 12", total);
    end
    if (bad != 0) begin
      $display("test FAILED: total=%0d bad=%0d", total, bad);
    end else begin
      $display("test PASSED: total=%0d bad=%0d", total, bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
